comparador_serial_d_i: RTL and testbench
========================================

Name: comparador_serial_d_i

Overview:
- Bit-serial magnitude comparator controller.
- Captures two WIDTH-bit words on a start handshake.
- Walks the comparator cell recurrence right-to-left (LSB first), one bit per clock, using a single registered state bit x.
- Reports A<B and A==B with a one-cycle done pulse.
- Replaces the unrolled cell chain where area matters more than latency; sits between the operand registers and the decision logic.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH), width of the bit index counter; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- a_in  input  WIDTH  operand A; captured on accepted start.
- b_in  input  WIDTH  operand B; captured on accepted start.
- abort  input  1  cancels a comparison in progress.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse when results are valid.
- a_lt_b  output  1  final A<B result; held until the next accepted start.
- a_eq_b  output  1  final A==B result; held until the next accepted start.

Behaviour:
- Single clock, one domain. Reset is synchronous and active-low: on a clk edge with rst_n=0, all state clears.
- Reset values: state=IDLE, busy=0, done=0, a_lt_b=0, a_eq_b=0, x=0, idx=0, shift registers=0.
- FSM states: IDLE, RUN, FIN.
  - IDLE: start=1 captures a_in/b_in into shift registers sa/sb, sets idx=0, x=0, eq=1, busy=1, and moves to RUN. start=0 stays in IDLE. a_lt_b and a_eq_b are held.
  - RUN, each cycle, with a=sa[0], b=sb[0]:
    - idx==0 (initial cell): x <= ~a & b.
    - idx>0: x <= (~a & b) | (~(a^b) & x).
    - eq <= eq & ~(a^b).
    - sa and sb shift right one bit; idx increments.
    - After the idx==WIDTH-1 update, move to FIN.
  - FIN, one cycle: a_lt_b <= x, a_eq_b <= eq, done=1, busy=0, then return to IDLE.
- Latency: start sampled at edge 0; done is high in the cycle after edge WIDTH+1, i.e. start-to-done is WIDTH+1 clocks. Throughput is one comparison per WIDTH+2 clocks.
- start while busy or in FIN: ignored, not queued.
- abort=1 in RUN: return to IDLE next edge. No done pulse. a_lt_b and a_eq_b keep their previous values; busy=0.
- abort in IDLE or FIN: no effect.
- abort and start in the same IDLE cycle: start wins (abort is meaningless in IDLE).
- rst_n=0 mid-RUN: all outputs take reset values on that edge; the comparison is lost.
- Operands: changes to a_in/b_in after capture have no effect.
- Equal operands: x stays 0, giving a_lt_b=0 and a_eq_b=1.
- a_lt_b and a_eq_b are never both 1.
- done is never high for two consecutive cycles.

Optional Feature:
- Macro: COMPARADOR_SIGNED_EN.
- Defined: operands are two's complement. At idx==WIDTH-1 the cell uses x <= (a & ~b) | (~(a^b) & x), i.e. the MSB weight is negated. eq logic is unchanged.
- Undefined: unsigned comparison for all bits. Latency and ports are identical in both builds.

Test Plan (WIDTH=8):
- Reset: rst_n=0 for 2 cycles → busy=0, done=0, a_lt_b=0, a_eq_b=0.
- Unsigned less: start with a=0x12, b=0x34 → done 9 clocks later; a_lt_b=1, a_eq_b=0; busy high exactly 8 cycles.
- Unsigned greater and equal, back-to-back:
  - a=0xF0, b=0x0F → a_lt_b=0, a_eq_b=0.
  - Next start in the IDLE cycle after done, a=0xA5, b=0xA5 → a_lt_b=0, a_eq_b=1.
- LSB-only difference: a=0x80, b=0x81 → a_lt_b=1. Then a=0x81, b=0x80 → a_lt_b=0.
- Control hazards:
  - start pulsed during RUN with a different pair → ignored; results match the first pair.
  - abort at idx=4 → no done; outputs unchanged.
  - rst_n=0 at idx=3 → reset values next cycle.
- Signed build: a=0xFF (-1), b=0x01 → a_lt_b=1 with COMPARADOR_SIGNED_EN, a_lt_b=0 without.

Source files
------------

// File: rtl/comparador_serial_d_i.sv
// ---------------------------------------------------------------------------
// comparador_serial_d_i
//
// Bit-serial magnitude comparator controller. Two WIDTH-bit operands are
// captured on an accepted start request. The comparator cell recurrence is
// then evaluated one bit per clock, LSB first, using one registered state
// bit x. The result is reported as a_lt_b / a_eq_b with a one-cycle done
// pulse. This block trades latency for area compared with an unrolled
// cell chain.
//
// Optional build macro:
//   COMPARADOR_SIGNED_EN  - when defined, operands are two's complement.
//                           The MSB cell uses the negated-weight recurrence.
//                           When undefined, all bits are compared unsigned.
//                           Latency and ports are the same in both builds.
//
// Parameters:
//   WIDTH  operand width in bits, legal range 2..32 (default 8)
//   CNT_W  bit index counter width, derived as $clog2(WIDTH)
//
// Ports:
//   clk     in   1      rising-edge clock
//   rst_n   in   1      synchronous active-low reset
//   start   in   1      comparison request, sampled only in IDLE
//   a_in    in   WIDTH  operand A, captured on accepted start
//   b_in    in   WIDTH  operand B, captured on accepted start
//   abort   in   1      cancels a comparison in progress (RUN only)
//   busy    out  1      high while the bit walk is running
//   done    out  1      one-cycle pulse when a_lt_b / a_eq_b are fresh
//   a_lt_b  out  1      A < B, held until the next accepted start
//   a_eq_b  out  1      A == B, held until the next accepted start
// ---------------------------------------------------------------------------
module comparador_serial_d_i #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             a_lt_b,
    output logic             a_eq_b
);

    localparam int CNT_W = $clog2(WIDTH);

    // Index of the last (most significant) cell of the walk.
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    // Reject illegal widths at elaboration rather than building a
    // comparator with a degenerate counter.
    if (WIDTH < 2 || WIDTH > 32) begin : g_width_check
        $error("comparador_serial_d_i: WIDTH must be in 2..32");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [CNT_W-1:0] idx;
    logic             x;
    logic             eq;

    logic             bit_a;
    logic             bit_b;
    logic             bits_same;
    logic             x_next;
    logic             eq_next;

    // One comparator cell, evaluated on the current LSBs of the shift
    // registers. x means "A < B considering the bits seen so far". A more
    // significant bit that differs overrides everything below it. Only when
    // the bits are equal does the lower-order verdict carry upward.
    always_comb begin
        bit_a     = sa[0];
        bit_b     = sb[0];
        bits_same = ~(bit_a ^ bit_b);
        x_next    = 1'b0;

        if (idx == '0) begin
            // First cell has no lower-order history to inherit.
            x_next = ~bit_a & bit_b;
`ifdef COMPARADOR_SIGNED_EN
        end else if (idx == LAST_IDX) begin
            // The sign bit carries negative weight, so a set MSB in A,
            // with a clear MSB in B, makes A the smaller operand.
            x_next = (bit_a & ~bit_b) | (bits_same & x);
`endif
        end else begin
            x_next = (~bit_a & bit_b) | (bits_same & x);
        end

        eq_next = eq & bits_same;
    end

    // Control FSM with all outputs registered. done defaults low every
    // cycle, so it can only be a single-cycle pulse. a_lt_b and a_eq_b are
    // written only in FIN, so an abort or an ignored start leaves the
    // previous result visible.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            sa     <= '0;
            sb     <= '0;
            idx    <= '0;
            x      <= 1'b0;
            eq     <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            a_lt_b <= 1'b0;
            a_eq_b <= 1'b0;
        end else begin
            done <= 1'b0;

            case (state)
                IDLE: begin
                    // abort has no meaning here, so start always wins.
                    if (start) begin
                        sa    <= a_in;
                        sb    <= b_in;
                        idx   <= '0;
                        x     <= 1'b0;
                        eq    <= 1'b1;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end

                RUN: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        x   <= x_next;
                        eq  <= eq_next;
                        sa  <= {1'b0, sa[WIDTH-1:1]};
                        sb  <= {1'b0, sb[WIDTH-1:1]};
                        idx <= idx + CNT_W'(1);
                        if (idx == LAST_IDX) begin
                            busy  <= 1'b0;
                            state <= FIN;
                        end
                    end
                end

                FIN: begin
                    // x and eq are mutually exclusive by construction.
                    // Once any bit differs, eq is cleared. While every bit
                    // matches, x stays 0.
                    a_lt_b <= x;
                    a_eq_b <= eq;
                    done   <= 1'b1;
                    state  <= IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_comparador_serial_d_i.sv
// ---------------------------------------------------------------------------
// tb_comparador_serial_d_i
//
// Directed testbench for comparador_serial_d_i with WIDTH=8. Expected results
// are hand-computed per vector. Where signed and unsigned interpretations
// differ, the expected value follows the COMPARADOR_SIGNED_EN macro.
// ---------------------------------------------------------------------------
module tb_comparador_serial_d_i;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic       abort;
    logic       busy;
    logic       done;
    logic       a_lt_b;
    logic       a_eq_b;

    int n_vectors;
    int n_miscompares;

    comparador_serial_d_i #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a_in   (a_in),
        .b_in   (b_in),
        .abort  (abort),
        .busy   (busy),
        .done   (done),
        .a_lt_b (a_lt_b),
        .a_eq_b (a_eq_b)
    );

    // 10 ns free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock, then settle 1 ns past the edge before driving
    // or sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single comparison point. Every check in the bench goes through here.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_vectors++;
        assert (observed === expected)
        else begin
            n_miscompares++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Start a comparison and wait, with a bound, for the done pulse. The
    // task returns in the done cycle, so the next start can follow
    // back-to-back. When inj_at >= 0, a competing start with another
    // operand pair is pulsed at cycle inj_at (RUN) and at cycle inj_at+5.
    // For inj_at = 3, the second pulse falls in the FIN cycle (cycle 8).
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                                 input int inj_at, output int cycles,
                                 output int busy_cnt);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        // Operands change after capture; the result must not follow them.
        a_in  = ~a;
        b_in  = ~b;
        cycles   = 0;
        busy_cnt = 0;
        while (done !== 1'b1 && cycles < 20) begin
            if (inj_at >= 0 && (cycles == inj_at || cycles == inj_at + 5)) begin
                start = 1'b1;
                a_in  = 8'h01;
                b_in  = 8'h02;
            end else begin
                start = 1'b0;
            end
            if (busy === 1'b1) busy_cnt++;
            tick();
            cycles++;
        end
        start = 1'b0;
    endtask

    int cyc;
    int bcnt;
    int dcnt;

    initial begin
        n_vectors     = 0;
        n_miscompares = 0;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        a_in  = 8'h00;
        b_in  = 8'h00;

        // Reset held for two cycles.
        tick();
        tick();
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_lt",   a_lt_b, 0);
        checkOutput("rst_eq",   a_eq_b, 0);
        rst_n = 1'b1;
        tick();

        // 0x12 < 0x34: done after 9 clocks, busy for exactly 8 cycles.
        applyStimulus(8'h12, 8'h34, -1, cyc, bcnt);
        checkOutput("less_latency", cyc, 9);
        checkOutput("less_busy",    bcnt, 8);
        checkOutput("less_lt",      a_lt_b, 1);
        checkOutput("less_eq",      a_eq_b, 0);

        // 0xF0 vs 0x0F is unsigned greater, but signed -16 < 15.
        applyStimulus(8'hF0, 8'h0F, -1, cyc, bcnt);
        checkOutput("gt_latency", cyc, 9);
`ifdef COMPARADOR_SIGNED_EN
        checkOutput("gt_lt", a_lt_b, 1);
`else
        checkOutput("gt_lt", a_lt_b, 0);
`endif
        checkOutput("gt_eq", a_eq_b, 0);

        // Back-to-back: start is raised in the done cycle.
        applyStimulus(8'hA5, 8'hA5, -1, cyc, bcnt);
        checkOutput("eq_latency", cyc, 9);
        checkOutput("eq_lt", a_lt_b, 0);
        checkOutput("eq_eq", a_eq_b, 1);
        tick();
        checkOutput("done_single_pulse", done, 0);

        // Abort at idx=4 with a pair that would give lt=1. The outcome is
        // no done pulse, busy drops, and the A5/A5 result is kept.
        a_in  = 8'h01;
        b_in  = 8'h02;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("abort_busy", busy, 0);
        dcnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (done === 1'b1) dcnt++;
            tick();
        end
        checkOutput("abort_no_done", dcnt, 0);
        checkOutput("abort_lt_held", a_lt_b, 0);
        checkOutput("abort_eq_held", a_eq_b, 1);

        // LSB-only difference in both directions. Both operands are
        // negative in the signed build, so the order is the same.
        applyStimulus(8'h80, 8'h81, -1, cyc, bcnt);
        checkOutput("lsb_lt_a", a_lt_b, 1);
        checkOutput("lsb_eq_a", a_eq_b, 0);
        applyStimulus(8'h81, 8'h80, -1, cyc, bcnt);
        checkOutput("lsb_lt_b", a_lt_b, 0);
        checkOutput("lsb_eq_b", a_eq_b, 0);

        // Competing start during RUN and FIN with pair 01/02 is ignored.
        applyStimulus(8'h40, 8'h30, 3, cyc, bcnt);
        checkOutput("ign_latency", cyc, 9);
        checkOutput("ign_lt", a_lt_b, 0);
        checkOutput("ign_eq", a_eq_b, 0);
        tick();
        checkOutput("ign_not_queued", busy, 0);

        // 0xFF vs 0x01: unsigned 255 > 1, signed -1 < 1.
        applyStimulus(8'hFF, 8'h01, -1, cyc, bcnt);
`ifdef COMPARADOR_SIGNED_EN
        checkOutput("sgn_lt", a_lt_b, 1);
`else
        checkOutput("sgn_lt", a_lt_b, 0);
`endif
        checkOutput("sgn_eq", a_eq_b, 0);

        // Reset asserted at idx=3 clears everything on that edge.
        a_in  = 8'h01;
        b_in  = 8'h02;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        rst_n = 1'b0;
        tick();
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_done", done, 0);
        checkOutput("midrst_lt",   a_lt_b, 0);
        checkOutput("midrst_eq",   a_eq_b, 0);
        rst_n = 1'b1;
        tick();

        // Recovery after reset: 0x7F vs 0x80 is unsigned less, signed greater.
        applyStimulus(8'h7F, 8'h80, -1, cyc, bcnt);
        checkOutput("post_latency", cyc, 9);
        checkOutput("post_busy",    bcnt, 8);
`ifdef COMPARADOR_SIGNED_EN
        checkOutput("post_lt", a_lt_b, 0);
`else
        checkOutput("post_lt", a_lt_b, 1);
`endif
        checkOutput("post_eq", a_eq_b, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
